// File: rtl/depacketizer_4.sv
// ---------------------------------------------------------------------------
// depacketizer_4
//   Receive side of the 4-flit packetizer. Takes flits one per cycle from a
//   router ejection port, checks head/tail framing, reassembles the payload
//   and presents {data, dst, vc} on a registered valid/ready output.
//
// Ports
//   clk            clock
//   rst            asynchronous active-high reset
//   flit_in        flit: [FW-1]=valid [FW-2]=head [FW-3]=tail, then vc,
//                  then (head only) dst, then payload MSB-first
//   flit_valid_in  flit_in valid
//   flit_ready_out flit accepted when flit_valid_in & flit_ready_out
//   data_out       reassembled payload
//   dst_out        dst field of the head flit
//   vc_out         vc field of the head flit
//   valid_out      output word valid
//   ready_in       downstream ready
//   err_out        one-cycle pulse after a framing error
//
// Build option
//   DEPACK_VC_CHECK_EN : flits whose vc differs from ASSIGNED_VC are
//                        discarded with err_out; vc_out is tied to
//                        ASSIGNED_VC.
// ---------------------------------------------------------------------------
module depacketizer_4 #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_PKT        = 36,
    parameter int WIDTH_DATA       = 12,
    parameter int ASSIGNED_VC      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_PKT/4-1:0]      flit_in,
    input  logic                        flit_valid_in,
    output logic                        flit_ready_out,
    output logic [WIDTH_DATA-1:0]       data_out,
    output logic [ADDRESS_WIDTH-1:0]    dst_out,
    output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        err_out
);

    localparam int FW  = WIDTH_PKT / 4;
    localparam int AW  = ADDRESS_WIDTH;
    localparam int VCW = VC_ADDRESS_WIDTH;
    localparam int WD  = WIDTH_DATA;
    localparam int P1  = FW - 3 - AW - VCW;
    localparam int PN  = FW - 3 - VCW;
    localparam int SW  = P1 + 3 * PN;
    localparam int NUM_FLITS = (P1 >= WD)          ? 1 :
                               (P1 + PN >= WD)     ? 2 :
                               (P1 + 2 * PN >= WD) ? 3 : 4;
    localparam int CW  = 3;
    localparam logic [CW-1:0] NF = CW'(NUM_FLITS);

`ifdef DEPACK_VC_CHECK_EN
    localparam logic [VCW-1:0] AVC    = VCW'(ASSIGNED_VC);
    localparam logic [VCW-1:0] VC_RST = AVC;
`else
    localparam logic [VCW-1:0] VC_RST = '0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [SW-1:0]     s_q;
    logic [AW-1:0]     pkt_dst_q;
    logic [VCW-1:0]    pkt_vc_q;
    logic [WD-1:0]     data_q;
    logic [AW-1:0]     dst_q;
    logic [VCW-1:0]    vc_q;
    logic              valid_q;
    logic              err_q;

    // Flit field decode
    logic              f_valid;
    logic              f_head;
    logic              f_tail;
    logic [VCW-1:0]    f_vc;
    logic [AW-1:0]     f_dst;
    logic [VCW-1:0]    head_vc;
    logic              vc_bad;

    assign f_valid = flit_in[FW-1];
    assign f_head  = flit_in[FW-2];
    assign f_tail  = flit_in[FW-3];
    assign f_vc    = flit_in[FW-4 -: VCW];
    assign f_dst   = flit_in[FW-4-VCW -: AW];

`ifdef DEPACK_VC_CHECK_EN
    assign vc_bad  = (f_vc != AVC);
    assign head_vc = AVC;
`else
    logic unused_cfg;
    assign unused_cfg = (ASSIGNED_VC != 0);
    assign vc_bad  = 1'b0;
    assign head_vc = f_vc;
`endif

    logic accept;
    logic take;
    logic reject;
    logic out_hs;
    state_t st_eff;
    logic [CW-1:0] cnt_inc;

    assign flit_ready_out = (state_q != FULL) | ready_in;
    assign accept  = flit_valid_in & flit_ready_out;
    assign take    = accept & f_valid & ~vc_bad;
    assign reject  = accept & f_valid & vc_bad;
    assign out_hs  = (state_q == FULL) & ready_in;
    assign cnt_inc = cnt_q + CW'(1);

    // A FULL-state handshake frees the output in the same cycle, so an
    // incoming flit is judged as if the FSM were already back in IDLE.
    assign st_eff  = out_hs ? IDLE : state_q;

    // Next reassembly vectors: a head starts a fresh vector with P1 at the
    // top; body flit k lands at its fixed slot below earlier fields.
    logic [SW-1:0] s_head_d;
    logic [SW-1:0] s_body_d;

    always_comb begin
        s_head_d = '0;
        s_head_d[SW-1 -: P1] = flit_in[P1-1:0];
        s_body_d = s_q;
        for (int unsigned k = 0; k < 3; k++) begin
            if (cnt_q == CW'(k + 1)) begin
                s_body_d[SW-1-P1-k*PN -: PN] = flit_in[PN-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s_q       <= '0;
            pkt_dst_q <= '0;
            pkt_vc_q  <= VC_RST;
            data_q    <= '0;
            dst_q     <= '0;
            vc_q      <= VC_RST;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;

            if (out_hs) begin
                valid_q <= 1'b0;
                state_q <= IDLE;
            end

            if (reject) begin
                err_q <= 1'b1;
            end else if (take) begin
                if (f_head) begin
                    // Head in BODY abandons the partial packet and restarts.
                    if (st_eff == BODY) begin
                        err_q <= 1'b1;
                    end
                    pkt_dst_q <= f_dst;
                    pkt_vc_q  <= head_vc;
                    s_q       <= s_head_d;
                    cnt_q     <= CW'(1);
                    if (f_tail) begin
                        if (NUM_FLITS == 1) begin
                            state_q <= FULL;
                            valid_q <= 1'b1;
                            data_q  <= s_head_d[SW-1 -: WD];
                            dst_q   <= f_dst;
                            vc_q    <= head_vc;
                            cnt_q   <= '0;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end else begin
                        state_q <= BODY;
                    end
                end else if (st_eff == BODY) begin
                    s_q   <= s_body_d;
                    cnt_q <= cnt_inc;
                    if (f_tail && cnt_inc == NF) begin
                        state_q <= FULL;
                        valid_q <= 1'b1;
                        data_q  <= s_body_d[SW-1 -: WD];
                        dst_q   <= pkt_dst_q;
                        vc_q    <= pkt_vc_q;
                        cnt_q   <= '0;
                    end else if (f_tail || cnt_inc >= NF) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end else if (st_eff == IDLE) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign data_out  = data_q;
    assign dst_out   = dst_q;
    assign vc_out    = vc_q;
    assign valid_out = valid_q;
    assign err_out   = err_q;

endmodule
